// File: rtl/win_score_display.sv
// Multi-digit BCD win counter with active-low 7-segment outputs and a win/playfield-reset flag.
// Optional build macro WIN_SCORE_BLANK_LEADING_EN blanks digits above the most significant nonzero digit.
module win_score_display #(
    parameter int DIGITS    = 2,
    parameter int WIN_LIMIT = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pin,
    input  logic                  farMost,
    input  logic                  clear,
    output logic [7*DIGITS-1:0]   HEX,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic                  out,
    output logic                  done
);

    localparam logic [0:0] STATE_RUN  = 1'b0;
    localparam logic [0:0] STATE_DONE = 1'b1;

    function automatic logic [4*DIGITS-1:0] toBcd(input int value);
        int v;
        logic [4*DIGITS-1:0] bcd;
        v   = value;
        bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd[4*i +: 4] = 4'(v % 10);
            v             = v / 10;
        end
        return bcd;
    endfunction

    function automatic logic [6:0] segOf(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    localparam logic [4*DIGITS-1:0] LIMIT_BCD = toBcd(WIN_LIMIT);

    generate
        if (DIGITS < 1 || DIGITS > 4) begin : g_badDigits
            $error("win_score_display: DIGITS must be 1..4");
        end else if (WIN_LIMIT < 1 || WIN_LIMIT > (10 ** DIGITS) - 1) begin : g_badLimit
            $error("win_score_display: WIN_LIMIT out of range for DIGITS");
        end
    endgenerate

    logic                 r_evtQ;
    logic [4*DIGITS-1:0]  r_score;
    logic [0:0]           r_state;
    logic                 r_out;
    logic                 r_done;

    logic                 w_evt;
    logic                 w_inc;
    logic                 w_hitLimit;
    logic [4*DIGITS-1:0]  w_scoreInc;
    logic [DIGITS-1:0]    w_blank;

    assign w_evt      = pin & farMost;
    assign w_inc      = w_evt & ~r_evtQ;
    assign w_hitLimit = (w_scoreInc == LIMIT_BCD);

    // Ripple BCD increment: a digit at 9 wraps to 0 and passes the carry upward.
    always_comb begin : incBcd
        logic carry;
        carry      = 1'b1;
        w_scoreInc = r_score;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r_score[4*i +: 4] == 4'd9) begin
                    w_scoreInc[4*i +: 4] = 4'd0;
                end else begin
                    w_scoreInc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
    end

    // Clear beats everything; evt_q keeps tracking so an event held across clear never counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_evtQ  <= 1'b0;
            r_score <= '0;
            r_state <= STATE_RUN;
            r_out   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_evtQ <= w_evt;
            if (clear) begin
                r_score <= '0;
                r_state <= STATE_RUN;
                r_out   <= 1'b0;
                r_done  <= 1'b0;
            end else if (r_state == STATE_DONE) begin
                r_out  <= 1'b1;
                r_done <= 1'b1;
            end else if (w_inc) begin
                r_score <= w_scoreInc;
                r_out   <= 1'b1;
                if (w_hitLimit) begin
                    r_state <= STATE_DONE;
                    r_done  <= 1'b1;
                end
            end else begin
                r_out <= 1'b0;
            end
        end
    end

`ifdef WIN_SCORE_BLANK_LEADING_EN
    // Walk down from the top digit; a digit is blank while every digit above it is also zero.
    always_comb begin : blankLeading
        logic allZeroAbove;
        allZeroAbove = 1'b1;
        w_blank      = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            allZeroAbove = allZeroAbove & (r_score[4*i +: 4] == 4'd0);
            w_blank[i]   = allZeroAbove;
        end
    end
`else
    assign w_blank = '0;
`endif

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_hex
            assign HEX[7*g +: 7] = w_blank[g] ? 7'b1111111 : segOf(r_score[4*g +: 4]);
        end
    endgenerate

    assign score_bcd = r_score;
    assign out       = r_out;
    assign done      = r_done;

endmodule

// File: tb/tb_win_score_display.sv
// Directed bench for win_score_display: four parameter sets share one input stream.
// Expected HEX follows the WIN_SCORE_BLANK_LEADING_EN build when that macro is defined.
module tb_win_score_display;

    logic clk;
    logic reset;
    logic pin;
    logic farMost;
    logic clear;

    logic [13:0] hexA;
    logic [7:0]  scoreA;
    logic        outA;
    logic        doneA;
    logic [13:0] hexB;
    logic [7:0]  scoreB;
    logic        outB;
    logic        doneB;
    logic [6:0]  hexC;
    logic [3:0]  scoreC;
    logic        outC;
    logic        doneC;
    logic [20:0] hexD;
    logic [11:0] scoreD;
    logic        outD;
    logic        doneD;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       pin;
        logic       farMost;
        logic       clear;
        logic [7:0] score;
        logic       out;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    win_score_display #(.DIGITS(2), .WIN_LIMIT(7)) dutA (
        .clk(clk), .reset(reset), .pin(pin), .farMost(farMost), .clear(clear),
        .HEX(hexA), .score_bcd(scoreA), .out(outA), .done(doneA)
    );
    win_score_display #(.DIGITS(2), .WIN_LIMIT(15)) dutB (
        .clk(clk), .reset(reset), .pin(pin), .farMost(farMost), .clear(clear),
        .HEX(hexB), .score_bcd(scoreB), .out(outB), .done(doneB)
    );
    win_score_display #(.DIGITS(1), .WIN_LIMIT(7)) dutC (
        .clk(clk), .reset(reset), .pin(pin), .farMost(farMost), .clear(clear),
        .HEX(hexC), .score_bcd(scoreC), .out(outC), .done(doneC)
    );
    win_score_display #(.DIGITS(3), .WIN_LIMIT(200)) dutD (
        .clk(clk), .reset(reset), .pin(pin), .farMost(farMost), .clear(clear),
        .HEX(hexD), .score_bcd(scoreD), .out(outD), .done(doneD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] BLANK = 7'b1111111;

    function automatic logic [6:0] segRef(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Zero shown in a non-units digit: blank in the blanking build, "0" otherwise.
    function automatic logic [6:0] leadZero();
`ifdef WIN_SCORE_BLANK_LEADING_EN
        return BLANK;
`else
        return 7'b1000000;
`endif
    endfunction

    function automatic logic [13:0] hex2Ref(input logic [7:0] s);
        logic [6:0] upper;
        upper = (s[7:4] == 4'd0) ? leadZero() : segRef(s[7:4]);
        return {upper, segRef(s[3:0])};
    endfunction

    task automatic addVec(input logic p, input logic f, input logic c,
                          input logic [7:0] s, input logic o, input logic d);
        vec_t v;
        v.pin = p; v.farMost = f; v.clear = c; v.score = s; v.out = o; v.done = d;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic p, input logic f, input logic c);
        @(negedge clk);
        pin     = p;
        farMost = f;
        clear   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic separatedEvents(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset   = 1'b0;
        pin     = 1'b0;
        farMost = 1'b0;
        clear   = 1'b0;

        // Held event, out pulse, clear with held and with rising event, count to limit, extra events, clear in DONE.
        addVec(0,0,0, 8'h00,0,0); addVec(1,0,0, 8'h00,0,0); addVec(0,1,0, 8'h00,0,0);
        addVec(1,1,0, 8'h01,1,0); addVec(1,1,0, 8'h01,0,0); addVec(1,1,0, 8'h01,0,0);
        addVec(1,1,0, 8'h01,0,0); addVec(1,1,0, 8'h01,0,0); addVec(0,0,0, 8'h01,0,0);
        addVec(1,1,0, 8'h02,1,0); addVec(0,0,0, 8'h02,0,0); addVec(1,1,0, 8'h03,1,0);
        addVec(0,1,0, 8'h03,0,0); addVec(1,1,0, 8'h04,1,0); addVec(1,1,1, 8'h00,0,0);
        addVec(1,1,0, 8'h00,0,0); addVec(0,0,0, 8'h00,0,0); addVec(1,1,0, 8'h01,1,0);
        addVec(0,0,0, 8'h01,0,0); addVec(1,1,1, 8'h00,0,0); addVec(0,0,0, 8'h00,0,0);
        addVec(1,1,0, 8'h01,1,0); addVec(0,0,0, 8'h01,0,0); addVec(1,1,0, 8'h02,1,0);
        addVec(0,0,0, 8'h02,0,0); addVec(1,1,0, 8'h03,1,0); addVec(0,0,0, 8'h03,0,0);
        addVec(1,1,0, 8'h04,1,0); addVec(0,0,0, 8'h04,0,0); addVec(1,1,0, 8'h05,1,0);
        addVec(0,0,0, 8'h05,0,0); addVec(1,1,0, 8'h06,1,0); addVec(0,0,0, 8'h06,0,0);
        addVec(1,1,0, 8'h07,1,1); addVec(0,0,0, 8'h07,1,1); addVec(1,1,0, 8'h07,1,1);
        addVec(0,0,0, 8'h07,1,1); addVec(1,1,0, 8'h07,1,1); addVec(0,0,0, 8'h07,1,1);
        addVec(1,1,1, 8'h00,0,0); addVec(1,1,0, 8'h00,0,0); addVec(0,0,0, 8'h00,0,0);

        #12;
        checkOutput("reset scoreA", 32'(scoreA), 32'h00);
        checkOutput("reset outA",   32'(outA),   32'h0);
        checkOutput("reset doneA",  32'(doneA),  32'h0);
        checkOutput("reset hexA",   32'(hexA),   32'(hex2Ref(8'h00)));
        checkOutput("reset hexC",   32'(hexC),   32'(7'b1000000));
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].pin, vecs[i].farMost, vecs[i].clear);
            checkOutput($sformatf("vec%0d scoreA", i), 32'(scoreA), 32'(vecs[i].score));
            checkOutput($sformatf("vec%0d outA", i),   32'(outA),   32'(vecs[i].out));
            checkOutput($sformatf("vec%0d doneA", i),  32'(doneA),  32'(vecs[i].done));
            checkOutput($sformatf("vec%0d hexA", i),   32'(hexA),   32'(hex2Ref(vecs[i].score)));
            checkOutput($sformatf("vec%0d scoreC", i), 32'(scoreC), 32'(vecs[i].score[3:0]));
            checkOutput($sformatf("vec%0d outC", i),   32'(outC),   32'(vecs[i].out));
            checkOutput($sformatf("vec%0d doneC", i),  32'(doneC),  32'(vecs[i].done));
            checkOutput($sformatf("vec%0d hexC", i),   32'(hexC),   32'(segRef(vecs[i].score[3:0])));
        end

        // Five events: three-digit instance shows "5" with two upper digits.
        separatedEvents(5);
        checkOutput("five scoreD",   32'(scoreD),      32'h005);
        checkOutput("five hexD lo",  32'(hexD[6:0]),   32'(7'b0010010));
        checkOutput("five hexD hi",  32'(hexD[20:7]),  32'({leadZero(), leadZero()}));

        // Five more: carry into tens on the 15-limit instance.
        separatedEvents(5);
        checkOutput("carry scoreB",  32'(scoreB),      32'h10);
        checkOutput("carry hexB lo", 32'(hexB[6:0]),   32'(7'b1000000));
        checkOutput("carry hexB hi", 32'(hexB[13:7]),  32'(7'b1111001));
        checkOutput("carry doneB",   32'(doneB),       32'h0);
        checkOutput("carry scoreA",  32'(scoreA),      32'h07);
        checkOutput("carry doneA",   32'(doneA),       32'h1);
        checkOutput("carry hexD",    32'(hexD),        32'({leadZero(), 7'b1111001, 7'b1000000}));

        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("clr scoreB",    32'(scoreB),      32'h00);
        checkOutput("clr doneA",     32'(doneA),       32'h0);
        checkOutput("clr hexD lo",   32'(hexD[6:0]),   32'(7'b1000000));
        checkOutput("clr hexD hi",   32'(hexD[20:7]),  32'({leadZero(), leadZero()}));

        // Asynchronous reset between edges, right after an increment raised out.
        separatedEvents(2);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("pre-reset scoreA", 32'(scoreA), 32'h03);
        checkOutput("pre-reset outA",   32'(outA),   32'h1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async scoreA", 32'(scoreA), 32'h00);
        checkOutput("async outA",   32'(outA),   32'h0);
        checkOutput("async doneA",  32'(doneA),  32'h0);
        checkOutput("async hexA",   32'(hexA),   32'(hex2Ref(8'h00)));
        checkOutput("async scoreD", 32'(scoreD), 32'h000);

        // Event still held while reset releases: evt_q restarted at 0, so it counts once.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post-reset scoreA", 32'(scoreA), 32'h01);
        checkOutput("post-reset outA",   32'(outA),   32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("post-reset held",   32'(scoreA), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
